// File: rtl/score_display_mux.sv
// Time-multiplexed common-anode 7-segment driver for a packed BCD score.
// One digit is scanned per refresh slot. Each slot opens with a dark interval
// so the previous digit's pattern cannot ghost onto the next anode. The score
// is sampled once per full frame, so a score that changes mid-scan never shows
// a mix of old and new digits. Leading zeros can optionally be blanked.
module score_display_mux #(
    parameter int BCD_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       en,
    input  logic [BCD_DIGITS-1:0][3:0] bcd,
    input  logic                       blank_lz,
    output logic [6:0]                 seg,
    output logic [BCD_DIGITS-1:0]      an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BCD_DIGITS - 1);

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-decimal codes
    // light only the middle bar so a corrupt score is visibly flagged.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]            cnt;
    logic [IDX_W-1:0]            idx;
    logic [BCD_DIGITS-1:0][3:0]  snap;

    logic                        slot_end;
    logic                        past_blank_p0;
    logic                        blank_p0;
    logic                        lit_p0;
    logic [3:0]                  digit_p0;
    logic [6:0]                  seg_p0;
    logic [BCD_DIGITS-1:0]       an_p0;

    assign slot_end = (cnt == CNT_LAST);

    // Slot prescaler, digit index and once-per-frame score snapshot.
    // Everything holds while en is low so a re-enable resumes mid-slot.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt  <= '0;
            idx  <= '0;
            snap <= '0;
        end else if (en) begin
            if (slot_end) begin
                cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx  <= '0;
                    snap <= bcd;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // ---- stage p0: combinational view of the current slot ----

    // Anti-ghosting window; with no blank interval the anode is lit all slot.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign past_blank_p0 = 1'b1;
        end else begin : g_blank
            assign past_blank_p0 = (cnt >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // Leading-zero test: the digit and every more significant one are zero.
    // Digit 0 always shows so a zero score still reads "0".
    always_comb begin
        blank_p0 = blank_lz && (idx != '0);
        for (int j = 0; j < BCD_DIGITS; j++) begin
            if ((j >= int'(idx)) && (snap[j] != 4'd0)) begin
                blank_p0 = 1'b0;
            end
        end
    end

    assign digit_p0 = snap[idx];
    assign lit_p0   = en && past_blank_p0 && !blank_p0;

    // Select the single active anode and its pattern; dark means all segments off.
    always_comb begin
        an_p0  = '1;
        seg_p0 = 7'h7F;
        if (lit_p0) begin
            an_p0[idx] = 1'b0;
            seg_p0     = seg_decode(digit_p0);
        end
    end

    // ---- stage p1: registered pad drive ----

    // Register the pad outputs so the pins never glitch between digits.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            seg <= 7'h7F;
            an  <= '1;
        end else begin
            seg <= seg_p0;
            an  <= an_p0;
        end
    end

endmodule

// File: tb/tb_score_display_mux.sv
// Bench for score_display_mux: BCD_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// The stimulus side queues the expected pad state for every clock it issues;
// a monitor on the falling edge pops and compares.
module tb_score_display_mux;

    localparam int ND  = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;

    logic                clk = 1'b0;
    logic                arst;
    logic                en;
    logic [ND-1:0][3:0]  bcd;
    logic                blank_lz;
    logic [6:0]          seg;
    logic [ND-1:0]       an;

    score_display_mux #(
        .BCD_DIGITS  (ND),
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk     (clk),
        .arst    (arst),
        .en      (en),
        .bcd     (bcd),
        .blank_lz(blank_lz),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [3:0] m_an;
        logic [6:0] m_seg;
        bit         hv;
        logic [3:0] h_an;
        logic [6:0] h_seg;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   k = 0;

    // Reference state of the scanner
    int         m_cnt;
    int         m_idx;
    logic [3:0] m_snap [ND];

    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    task automatic check(input string nm, input logic [3:0] a_an, input logic [6:0] a_seg,
                         input logic [3:0] e_an, input logic [6:0] e_seg);
        n_checks++;
        if (a_an !== e_an || a_seg !== e_seg) begin
            n_errors++;
            $display("FAIL %s: got an=%b seg=%b, want an=%b seg=%b", nm, a_an, a_seg, e_an, e_seg);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_idx = 0;
        for (int j = 0; j < ND; j++) m_snap[j] = 4'd0;
    endtask

    task automatic model_out(output logic [3:0] o_an, output logic [6:0] o_seg);
        int msd;
        bit lit;
        msd = -1;
        for (int j = 0; j < ND; j++) if (m_snap[j] != 4'd0) msd = j;
        lit = en && (m_cnt >= BLK) && (m_idx == 0 || !blank_lz || m_idx <= msd);
        o_an  = 4'hF;
        o_seg = 7'h7F;
        if (lit) begin
            o_an[m_idx] = 1'b0;
            o_seg = seg_lut[m_snap[m_idx]];
        end
    endtask

    task automatic model_step();
        if (en) begin
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                if (m_idx == ND - 1) begin
                    m_idx = 0;
                    for (int j = 0; j < ND; j++) m_snap[j] = bcd[j];
                end else begin
                    m_idx++;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    // One clock: queue the expectation for the output after this edge, then advance.
    task automatic cycle(input string nm, input bit hv, input logic [3:0] ha, input logic [6:0] hs);
        exp_t e;
        e.nm = nm;
        model_out(e.m_an, e.m_seg);
        e.hv = hv;
        e.h_an = ha;
        e.h_seg = hs;
        q.push_back(e);
        @(posedge clk);
        model_step();
        k++;
        #1;
    endtask

    task automatic run_to(input int target);
        while (k < target) cycle("scan", 1'b0, 4'h0, 7'h00);
    endtask

    task automatic chk_at(input int target, input string nm, input logic [3:0] ha, input logic [6:0] hs);
        run_to(target - 1);
        cycle(nm, 1'b1, ha, hs);
    endtask

    // Monitor: pads are compared on the falling edge, half a period after update.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.nm, "_model"}, an, seg, e.m_an, e.m_seg);
                if (e.hv) check(e.nm, an, seg, e.h_an, e.h_seg);
                n_checks++;
                if ($countones(~an) > 1) begin
                    n_errors++;
                    $display("FAIL onehot_%s: got an=%b, want at most one low bit", e.nm, an);
                end
            end
        end
    end

    initial begin
        arst     = 1'b1;
        en       = 1'b0;
        bcd      = 16'h0000;
        blank_lz = 1'b1;
        model_reset();
        #2;
        check("reset_async", an, seg, 4'hF, 7'h7F);
        @(posedge clk);
        #1;
        check("reset_held", an, seg, 4'hF, 7'h7F);
        @(negedge clk);
        #1;
        en   = 1'b1;
        arst = 1'b0;

        // Zero score with leading-zero blanking
        chk_at(2,  "t1_blank_win", 4'hF, 7'h7F);
        chk_at(3,  "t1_d0_zero",   4'hE, 7'h40);
        chk_at(11, "t1_d1_dark",   4'hF, 7'h7F);
        run_to(20);
        bcd = 16'h1234;

        // Second frame shows the snapshot of 1234
        chk_at(35, "t2_d0", 4'hE, 7'h19);
        chk_at(43, "t2_d1", 4'hD, 7'h30);
        chk_at(51, "t2_d2", 4'hB, 7'h24);
        chk_at(57, "t2_d3_blankwin", 4'hF, 7'h7F);
        chk_at(59, "t2_d3", 4'h7, 7'h79);
        run_to(60);
        bcd = 16'h0024;

        // Mid-frame score change stays hidden until the frame wraps
        chk_at(67, "t3_d0_old", 4'hE, 7'h19);
        bcd = 16'h0023;
        chk_at(70, "t3_d0_hold", 4'hE, 7'h19);
        chk_at(75, "t3_d1", 4'hD, 7'h24);
        chk_at(83, "t3_d2_lz", 4'hF, 7'h7F);
        chk_at(99, "t3_d0_new", 4'hE, 7'h30);
        run_to(100);
        bcd = 16'h0007;

        // Leading-zero blanking toggled mid-frame
        chk_at(131, "t4_d0", 4'hE, 7'h78);
        chk_at(139, "t4_d1_lz", 4'hF, 7'h7F);
        blank_lz = 1'b0;
        chk_at(140, "t4_d1_shown", 4'hD, 7'h40);
        chk_at(147, "t4_d2_shown", 4'hB, 7'h40);
        run_to(150);
        bcd = 16'h00C5;

        // Non-decimal code shows a dash
        chk_at(163, "t5_d0", 4'hE, 7'h12);
        chk_at(171, "t5_dash", 4'hD, 7'h3F);

        // Scan freeze and resume
        chk_at(173, "t6_pre_freeze", 4'hD, 7'h3F);
        en = 1'b0;
        chk_at(174, "t6_frozen_first", 4'hF, 7'h7F);
        chk_at(193, "t6_frozen_last", 4'hF, 7'h7F);
        en = 1'b1;
        chk_at(194, "t6_resume", 4'hD, 7'h3F);
        chk_at(197, "t6_next_blankwin", 4'hF, 7'h7F);
        chk_at(199, "t6_next_digit", 4'hB, 7'h40);
        run_to(203);

        // Asynchronous reset in the middle of a slot
        @(negedge clk);
        #1;
        arst = 1'b1;
        #1;
        check("t6_arst_async", an, seg, 4'hF, 7'h7F);
        model_reset();
        k = 0;
        #1;
        arst = 1'b0;
        chk_at(2,  "t7_blank_win", 4'hF, 7'h7F);
        chk_at(3,  "t7_d0_zero",   4'hE, 7'h40);
        chk_at(11, "t7_d1_zero",   4'hD, 7'h40);
        chk_at(35, "t7_d0_snap",   4'hE, 7'h12);
        run_to(40);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
